// File: rtl/bram_stream_pkg.sv
// Shared types and helpers for the burst-read weight BRAM.
// Holds the sequencer state encoding and the modulo-depth address increment.
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned addr_inc(input int unsigned addr, input int unsigned depth);
        return (addr + 1 >= depth) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// 2-entry valid/ready FIFO holding words read from the BRAM.
// Zero-latency head view; push is ignored when full, pop is ignored when empty.
module stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head_dat,
    output logic         vld
);

    logic [W-1:0] slot_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != 2'd0);
        push_ok  = push && (count_q != 2'd2);
        wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_ok ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            slot_q[wr_ptr_q] <= push_dat;
        end
    end

    assign count    = count_q;
    assign vld      = (count_q != 2'd0);
    assign head_dat = slot_q[rd_ptr_q];

endmodule

// File: rtl/bram_stream.sv
// Weight BRAM with a write/load port and a burst-read sequencer streaming words on valid/ready.
// First beat two cycles after start; a 2-entry buffer absorbs backpressure with no lost or repeated beats.
module bram_stream
    import bram_stream_pkg::*;
#(
    parameter int    L        = 176,
    parameter int    W        = 128,
    parameter string MEM_FILE = "mem_w.hex",
    localparam int   AW       = $clog2(L),
    localparam int   CW       = $clog2(L) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [CW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    input  logic          rd_ready
);

    logic [W-1:0] mem [L];

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] accepted_q, accepted_d;
    logic          done_q, done_d;
    logic          issue, accept;
    logic [1:0]    fifo_cnt;

    // Read-first: the issuing edge captures the old word even if it is overwritten on that edge.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < L)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The registered read lands directly in the buffer, so nothing is ever in flight
    // when the issue decision is made and buffer occupancy alone reserves the slot.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        accept     = rd_valid && rd_ready;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d     = base;
                        len_d      = len;
                        issued_d   = '0;
                        accepted_d = '0;
                        state_d    = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if ((fifo_cnt < 2'd2) && (issued_q < len_q)) begin
                    issue    = 1'b1;
                    issued_d = issued_q + 1'b1;
                    addr_d   = AW'(addr_inc(32'(addr_q), L));
                end
                if (accept) begin
                    accepted_d = accepted_q + 1'b1;
                end
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    accepted_d = accepted_q + 1'b1;
                end
                if (accepted_d == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            done_q     <= done_d;
        end
    end

    stream_fifo2 #(.W(W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue),
        .push_dat (mem[addr_q]),
        .pop      (accept),
        .count    (fifo_cnt),
        .head_dat (rd_data),
        .vld      (rd_valid)
    );

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_bram_stream.sv
// Self-checking bench for bram_stream: vector table, hand-written corner sequences, randomized bursts.
module tb_bram_stream;
    localparam int L  = 176;
    localparam int W  = 128;
    localparam int AW = $clog2(L);
    localparam int CW = $clog2(L) + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic [AW-1:0] base;
    logic [CW-1:0] len;
    logic          busy, done, rd_valid, rd_ready;
    logic [W-1:0]  rd_data;

    logic [W-1:0]  ref_mem [L];
    int            n_tests = 0;
    int            n_fail  = 0;

    typedef struct {
        int         b;
        int         n;
        int         mode;
        logic [W-1:0] first;
        logic [W-1:0] last;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    bram_stream #(.L(L), .W(W), .MEM_FILE("")) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base(base), .len(len), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic write_word(input int a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < L) ref_mem[a] = d;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    // noise: re-assert start with other parameters mid-burst.
    task automatic run_burst(input int b, input int n, input int mode, input bit noise, input string tag,
                             output logic [W-1:0] first_dat, output logic [W-1:0] last_dat);
        int           k = 0;
        int           cyc = 0;
        int           first_cyc = -1;
        int           budget = 8 * n + 50;
        bit           stalled = 0;
        bit           early_done = 0;
        bit           hs;
        logic [W-1:0] held = '0;
        bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        first_dat = '0;
        last_dat  = '0;
        start = 1'b1;
        base  = AW'(b);
        len   = CW'(n);
        tick();
        start = 1'b0;
        while (k < n && cyc < budget) begin
            if (noise && cyc == 2) begin
                start = 1'b1;
                base  = AW'(50);
                len   = CW'(3);
            end else begin
                start = 1'b0;
            end
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            if (stalled) check({tag, " stable"}, rd_data, held);
            if (rd_valid && first_cyc < 0) first_cyc = cyc;
            if (done) early_done = 1;
            hs = rd_valid && rd_ready;
            if (hs) begin
                check({tag, " data"}, rd_data, ref_mem[(b + k) % L]);
                if (k == 0) first_dat = rd_data;
                last_dat = rd_data;
                k++;
            end
            stalled = rd_valid && !rd_ready;
            held    = rd_data;
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " beats before timeout"}, W'(k), W'(n));
        check({tag, " no early done"}, W'(early_done), '0);
        if (mode == 0) begin
            check({tag, " first valid cycle"}, W'(first_cyc + 1), W'(2));
            check({tag, " gapless end cycle"}, W'(cyc), W'(n + 1));
        end
        check({tag, " done pulse"}, W'(done), W'(1));
        check({tag, " busy low with done"}, W'(busy), '0);
        tick();
        check({tag, " done one cycle"}, W'(done), '0);
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] f, l;
        logic [W-1:0] old5;
        int           cnt;

        vecs[0] = '{b: 0,   n: 4,   mode: 0, first: W'(0),   last: W'(3)};
        vecs[1] = '{b: 174, n: 4,   mode: 0, first: W'(174), last: W'(1)};
        vecs[2] = '{b: 10,  n: 8,   mode: 1, first: W'(10),  last: W'(17)};
        vecs[3] = '{b: 170, n: 180, mode: 0, first: W'(170), last: W'(173)};
        vecs[4] = '{b: 100, n: 5,   mode: 2, first: W'(100), last: W'(104)};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base = '0; len = '0; rd_ready = 1'b0;
        repeat (2) tick();
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        check("reset rd_valid", W'(rd_valid), '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < L; i++) write_word(i, W'(i));

        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].b, vecs[v].n, vecs[v].mode, 1'b0, $sformatf("vec%0d", v), f, l);
            check($sformatf("vec%0d first", v), f, vecs[v].first);
            check($sformatf("vec%0d last", v), l, vecs[v].last);
        end

        // Zero-length burst: done next cycle, never busy, no beats.
        start = 1'b1; base = AW'(7); len = '0; rd_ready = 1'b1;
        tick();
        start = 1'b0;
        check("len0 done", W'(done), W'(1));
        check("len0 busy", W'(busy), '0);
        check("len0 rd_valid", W'(rd_valid), '0);
        tick();
        check("len0 done cleared", W'(done), '0);
        check("len0 still no valid", W'(rd_valid), '0);
        rd_ready = 1'b0;

        run_burst(0, 6, 0, 1'b1, "start while busy", f, l);
        check("start while busy last", l, W'(5));

        // Write to addr 5 on the same edge that reads it: old word must stream.
        old5 = ref_mem[5];
        start = 1'b1; base = AW'(5); len = CW'(2); rd_ready = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = {4{32'hA5A5A5A5}};
        tick();
        wr_en = 1'b0;
        ref_mem[5] = {4{32'hA5A5A5A5}};
        check("rdfirst valid", W'(rd_valid), W'(1));
        check("rdfirst old word", rd_data, old5);
        tick();
        check("rdfirst next word", rd_data, ref_mem[6]);
        tick();
        check("rdfirst done", W'(done), W'(1));
        rd_ready = 1'b0;
        tick();
        run_burst(5, 2, 0, 1'b0, "after write", f, l);
        check("after write new word", f, {4{32'hA5A5A5A5}});

        // Reset while beat 2 of a 10-beat burst is presented.
        start = 1'b1; base = '0; len = CW'(10); rd_ready = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            if (rd_valid && rd_ready) cnt++;
            tick();
        end
        check("mid reset beats seen", W'(cnt), W'(2));
        rst = 1'b1;
        #1;
        check("mid reset rd_valid", W'(rd_valid), '0);
        check("mid reset busy", W'(busy), '0);
        check("mid reset done", W'(done), '0);
        tick();
        rst = 1'b0;
        tick();
        check("post reset done", W'(done), '0);
        check("post reset rd_valid", W'(rd_valid), '0);
        rd_ready = 1'b0;
        run_burst(0, 10, 0, 1'b0, "post reset", f, l);

        // Randomized writes (including out-of-range addresses) and bursts.
        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < 6; w++) begin
                write_word(int'($urandom_range(0, 255)), {$urandom, $urandom, $urandom, $urandom});
            end
            run_burst(int'($urandom_range(0, L - 1)), int'($urandom_range(1, 40)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      $sformatf("rand%0d", r), f, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
